// File: rtl/stack_pkg.sv
// stack_pkg: default widths/depth and per-cycle operation decode shared by the LIFO stack
package stack_pkg;
  localparam int NDATA_DEF  = 8;
  localparam int NADDRW_DEF = 8;
  localparam int NADDRS_DEF = 8;
  typedef enum logic [2:0] {OP_NONE, OP_PUSH, OP_POP, OP_SWAP, OP_BYPASS} op_t;
  function automatic op_t decode(input logic push, input logic pop, input logic full, input logic empty);
    op_t o;
    o = OP_NONE;
    if (push && pop) begin
      if (empty) o = OP_BYPASS;
      else o = OP_SWAP;
    end else if (push && !full) o = OP_PUSH;
    else if (pop && !empty) o = OP_POP;
    return o;
  endfunction
endpackage

// File: rtl/stack_lifo_if.sv
// stack_lifo_if: push/pop request and response bundle; STACK_ERR_EN adds ovf, unf and err_clr
interface stack_lifo_if import stack_pkg::*; #(
  parameter int NDATA  = NDATA_DEF,
  parameter int NADDRW = NADDRW_DEF
);
  logic              push;
  logic              pop;
  logic [NDATA-1:0]  din;
  logic [NDATA-1:0]  dout;
  logic              dout_vld;
  logic              full;
  logic              empty;
  logic [NADDRW:0]   level;
`ifdef STACK_ERR_EN
  logic              err_clr;
  logic              ovf;
  logic              unf;
  modport master (output push, pop, din, err_clr, input dout, dout_vld, full, empty, level, ovf, unf);
  modport slave  (input push, pop, din, err_clr, output dout, dout_vld, full, empty, level, ovf, unf);
`else
  modport master (output push, pop, din, input dout, dout_vld, full, empty, level);
  modport slave  (input push, pop, din, output dout, dout_vld, full, empty, level);
`endif
endinterface

// File: rtl/stack_ram.sv
// stack_ram: storage array, one sync write and one sync read port; read-during-write returns old data
module stack_ram import stack_pkg::*; #(
  parameter int NDATA  = NDATA_DEF,
  parameter int NADDRW = NADDRW_DEF,
  parameter int NADDRS = NADDRS_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NADDRW-1:0] wa,
  input  logic [NDATA-1:0]  wd,
  input  logic              re,
  input  logic [NADDRW-1:0] ra,
  output logic [NDATA-1:0]  rd
);
  logic [NDATA-1:0] mem [NADDRS];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/stack_lifo.sv
// stack_lifo: downward-growing LIFO with registered pop data; define STACK_ERR_EN for sticky ovf/unf flags
module stack_lifo import stack_pkg::*; #(
  parameter int NDATA  = NDATA_DEF,
  parameter int NADDRW = NADDRW_DEF,
  parameter int NADDRS = NADDRS_DEF
) (
  input logic         clk,
  input logic         rst,
  stack_lifo_if.slave bus
);
  localparam logic [NADDRW:0] DEPTH = (NADDRW+1)'(NADDRS);
  localparam logic [NADDRW:0] ONE   = (NADDRW+1)'(1);
  logic [NADDRW:0]   level;
  logic [NADDRW-1:0] top_a;
  logic [NADDRW-1:0] free_a;
  logic [NDATA-1:0]  ram_q;
  logic [NDATA-1:0]  byp;
  logic [NDATA-1:0]  hold;
  logic              vld;
  logic              by;
  logic              we;
  logic              re;
  op_t               op;
  assign op     = decode(bus.push, bus.pop, bus.full, bus.empty);
  assign top_a  = NADDRW'(DEPTH - level);
  assign free_a = top_a - NADDRW'(1);
  assign we     = op == OP_PUSH || op == OP_SWAP;
  assign re     = op == OP_POP || op == OP_SWAP;
  stack_ram #(.NDATA(NDATA), .NADDRW(NADDRW), .NADDRS(NADDRS)) u_ram (
    .clk (clk),
    .we  (we),
    .wa  (op == OP_SWAP ? top_a : free_a),
    .wd  (bus.din),
    .re  (re),
    .ra  (top_a),
    .rd  (ram_q)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
      vld   <= 1'b0;
      by    <= 1'b0;
      byp   <= '0;
      hold  <= '0;
    end else begin
      level <= op == OP_PUSH ? level + ONE : op == OP_POP ? level - ONE : level;
      vld   <= op == OP_POP || op == OP_SWAP || op == OP_BYPASS;
      by    <= op == OP_BYPASS;
      if (op == OP_BYPASS) byp <= bus.din;
      if (vld) hold <= bus.dout;
    end
  end
  // ram_q is only trusted in the strobe cycle; hold keeps dout stable afterwards
  assign bus.dout     = !vld ? hold : by ? byp : ram_q;
  assign bus.dout_vld = vld;
  assign bus.full     = level == DEPTH;
  assign bus.empty    = level == '0;
  assign bus.level    = level;
`ifdef STACK_ERR_EN
  logic ovf;
  logic unf;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= (bus.push && !bus.pop && bus.full) || (ovf && !bus.err_clr);
      unf <= (bus.pop && !bus.push && bus.empty) || (unf && !bus.err_clr);
    end
  end
  assign bus.ovf = ovf;
  assign bus.unf = unf;
`endif
endmodule

// File: tb/tb_stack_lifo.sv
// tb_stack_lifo: directed stimulus with a queued scoreboard checked by an independent dout monitor
module tb_stack_lifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errs = 0;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  stack_lifo_if #(.NDATA(8), .NADDRW(8)) bus ();
  stack_lifo #(.NDATA(8), .NADDRW(8), .NADDRS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  task automatic chk(input string n, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic cyc(input logic p, input logic q, input logic [7:0] d);
    bus.push = p;
    bus.pop  = q;
    bus.din  = d;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask
  always @(negedge clk) begin
    if (bus.dout_vld) begin
      if (exp_q.size() == 0) chk("unexpected_dout_vld", 1, 0);
      else chk("sb_dout", int'(bus.dout), int'(exp_q.pop_front()));
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = '0;
`ifdef STACK_ERR_EN
    bus.err_clr = 1'b0;
`endif
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", int'(bus.level), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_vld", int'(bus.dout_vld), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 0, 8'h11);
    chk("push1_level", int'(bus.level), 1);
    chk("push1_empty", int'(bus.empty), 0);
    cyc(1, 0, 8'h22);
    cyc(1, 0, 8'h33);
    chk("push3_full", int'(bus.full), 0);
    cyc(1, 0, 8'h44);
    chk("push4_level", int'(bus.level), 4);
    chk("push4_full", int'(bus.full), 1);
    cyc(1, 0, 8'h55);
    chk("ovf_push_level", int'(bus.level), 4);
    chk("ovf_push_full", int'(bus.full), 1);
`ifdef STACK_ERR_EN
    chk("ovf_set", int'(bus.ovf), 1);
    bus.err_clr = 1'b1;
    cyc(1, 0, 8'h66);
    chk("ovf_set_wins", int'(bus.ovf), 1);
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    chk("ovf_clr", int'(bus.ovf), 0);
`endif
    exp_q.push_back(8'h44);
    cyc(0, 1, 8'h00);
    chk("pop1_level", int'(bus.level), 3);
    exp_q.push_back(8'h33);
    cyc(0, 1, 8'h00);
    exp_q.push_back(8'h22);
    cyc(0, 1, 8'h00);
    exp_q.push_back(8'h11);
    cyc(0, 1, 8'h00);
    chk("drain_empty", int'(bus.empty), 1);
    chk("drain_level", int'(bus.level), 0);
    @(posedge clk);
    #1;
    chk("hold_dout", int'(bus.dout), 8'h11);
    chk("hold_vld", int'(bus.dout_vld), 0);
    cyc(0, 1, 8'h00);
    chk("unf_pop_vld", int'(bus.dout_vld), 0);
    chk("unf_pop_dout", int'(bus.dout), 8'h11);
    chk("unf_pop_level", int'(bus.level), 0);
`ifdef STACK_ERR_EN
    chk("unf_set", int'(bus.unf), 1);
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    chk("unf_clr", int'(bus.unf), 0);
`endif
    cyc(1, 0, 8'hAA);
    exp_q.push_back(8'hAA);
    cyc(1, 1, 8'hBB);
    chk("swap_dout", int'(bus.dout), 8'hAA);
    chk("swap_level", int'(bus.level), 1);
    exp_q.push_back(8'hBB);
    cyc(0, 1, 8'h00);
    chk("swap_pop_empty", int'(bus.empty), 1);
    exp_q.push_back(8'h5C);
    cyc(1, 1, 8'h5C);
    chk("bypass_dout", int'(bus.dout), 8'h5C);
    chk("bypass_vld", int'(bus.dout_vld), 1);
    chk("bypass_level", int'(bus.level), 0);
    cyc(1, 0, 8'h77);
    cyc(1, 0, 8'h66);
    cyc(0, 1, 8'h00);
    rst = 1'b0;
    #1;
    chk("midrst_dout", int'(bus.dout), 0);
    chk("midrst_vld", int'(bus.dout_vld), 0);
    chk("midrst_level", int'(bus.level), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_vld", int'(bus.dout_vld), 0);
    cyc(1, 0, 8'h01);
    exp_q.push_back(8'h01);
    cyc(0, 1, 8'h00);
    chk("post_rst_dout", int'(bus.dout), 8'h01);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/stack_lifo.md
STACK_LIFO -- requirements
Module: stack_lifo

Interface
REQ-001 SHALL have parameter NDATA, default 8, data word width in bits.
REQ-002 SHALL have parameter NADDRW, default 8, memory address width in bits.
REQ-003 SHALL have parameter NADDRS, default 8, stack depth in words; legal range 2..2^NADDRW.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port push, input, 1, write din onto stack this cycle.
REQ-007 SHALL have port pop, input, 1, remove top word this cycle.
REQ-008 SHALL have port din, input, NDATA, data to push.
REQ-009 SHALL have port dout, output, NDATA, last popped word, registered.
REQ-010 SHALL have port dout_vld, output, 1, one-cycle strobe marking a new dout.
REQ-011 SHALL have port full, output, 1, stack holds NADDRS words.
REQ-012 SHALL have port empty, output, 1, stack holds zero words.
REQ-013 SHALL have port level, output, NADDRW+1, number of stored words.

Function
REQ-014 SHALL grow downward: first push to address NADDRS-1, successive pushes to decreasing addresses; top word at address NADDRS-level.
REQ-015 SHALL accept a push when not full: din written at the next free address, level +1.
REQ-016 SHALL accept a pop when not empty: top word returned on dout with dout_vld high exactly one cycle after the pop cycle, level -1.
REQ-017 SHALL, on push and pop together with level>0, return the old top on dout next cycle, overwrite the top with din, and leave level unchanged.
REQ-018 SHALL, on push and pop together with level=0, bypass din directly to dout next cycle with dout_vld high, level stays 0, and write no memory.
REQ-019 SHALL ignore a lone push when full: no write, level unchanged.
REQ-020 SHALL ignore a lone pop when empty: dout_vld stays low, dout holds its value.
REQ-021 SHALL hold dout stable between accepted pops; dout_vld is low in every cycle without an accepted pop.
REQ-022 SHALL derive full (level==NADDRS) and empty (level==0) from registered state, never from current-cycle inputs.
REQ-023 SHALL perform all address arithmetic modulo 2^NADDRW with no wrap beyond address 0 or NADDRS-1.

Reset
REQ-024 SHALL, while rst is low, force level=0, empty=1, full=0, dout=0, dout_vld=0, and the error flags to 0.
REQ-025 SHALL leave memory contents undefined after reset; no read of an unwritten word is visible.
REQ-026 SHALL abort any pop that is in flight when rst asserts: no dout_vld after reset release.

Configuration
REQ-027 SHALL, with STACK_ERR_EN defined, add outputs ovf and unf (1 bit each) and input err_clr (1 bit).
REQ-028 SHALL, with STACK_ERR_EN defined, set ovf sticky on a rejected push, set unf sticky on a rejected pop, and clear both on err_clr; set wins over a same-cycle clear.
REQ-029 SHALL, without STACK_ERR_EN, omit ovf, unf and err_clr entirely and reject illegal operations silently.

Structure
REQ-030 SHALL place the default widths and depth constants in shared package stack_pkg.
REQ-031 SHALL instantiate sub-module stack_ram: one synchronous write port and one synchronous read port, read-during-write to the same address returning old data.
REQ-032 SHALL keep the pointer, level and flag logic in stack_lifo; stack_ram holds no control state.

Verification
REQ-033 SHALL cover, with NADDRS=4: push 0x11,0x22,0x33,0x44 -> full=1, level=4; a 5th push of 0x55 -> level=4 and ovf=1.
REQ-034 SHALL cover draining that stack: 4 pops -> dout 0x44,0x33,0x22,0x11, each with a one-cycle dout_vld, then empty=1.
REQ-035 SHALL cover a pop at empty: no dout_vld, dout unchanged, and unf=1 with STACK_ERR_EN defined.
REQ-036 SHALL cover push 0xAA then push+pop of 0xBB in the same cycle: dout=0xAA, level=1, and a following pop returns 0xBB.
REQ-037 SHALL cover push+pop of 0x5C at empty: dout=0x5C with dout_vld high, and level stays 0.
REQ-038 SHALL cover rst asserted during the cycle after a pop: dout=0, dout_vld=0, level=0; then push 0x01 and pop -> dout=0x01.
